// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if
//   Bundles the signals around the memory-stage sequencer:
//   - req_*  : execute -> sequencer request handshake (valid/ready)
//   - lsu_*  : sequencer <-> lsu (held address/data/we, size strobes, busy, result)
//   - wb_*   : sequencer -> register file writeback beat
//   The slave modport is the sequencer's view; master is the environment's view
//   (execute stage, lsu and register file together).
interface mem_sequencer_if #(
  parameter int RD_W = 5
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [63:0]     req_addr_i;
  logic [63:0]     req_dat_i;
  logic            req_we_i;
  logic [1:0]      req_size_i;
  logic            req_unsigned_i;
  logic [RD_W-1:0] req_rd_i;

  logic [63:0]     lsu_addr_o;
  logic [63:0]     lsu_dat_o;
  logic            lsu_we_o;
  logic            lsu_nomem_o;
  logic            lsu_hword_o;
  logic            lsu_word_o;
  logic            lsu_dword_o;
  logic            lsu_busy_i;
  logic [63:0]     lsu_dat_i;

  logic            wb_valid_o;
  logic [RD_W-1:0] wb_rd_o;
  logic [63:0]     wb_dat_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_dat_i, req_we_i, req_size_i,
           req_unsigned_i, req_rd_i, lsu_busy_i, lsu_dat_i,
    output req_ready_o, lsu_addr_o, lsu_dat_o, lsu_we_o, lsu_nomem_o,
           lsu_hword_o, lsu_word_o, lsu_dword_o, wb_valid_o, wb_rd_o, wb_dat_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_dat_i, req_we_i, req_size_i,
           req_unsigned_i, req_rd_i, lsu_busy_i, lsu_dat_i,
    input  req_ready_o, lsu_addr_o, lsu_dat_o, lsu_we_o, lsu_nomem_o,
           lsu_hword_o, lsu_word_o, lsu_dword_o, wb_valid_o, wb_rd_o, wb_dat_o
  );
endinterface

// File: rtl/mem_sequencer.sv
// mem_sequencer
//   Memory-stage sequencer in front of the 16-bit Wishbone lsu. Accepts one
//   memory op at a time, holds address/store data for the whole bus cycle,
//   fires a one-cycle size strobe, waits for lsu busy to drop, then extends
//   the result and presents a one-cycle writeback beat.
// Ports:
//   clk_i    : clock
//   reset_i  : synchronous reset, active-low
//   bus      : mem_sequencer_if.slave (request, lsu and writeback signals)
module mem_sequencer #(
  parameter int RD_W = 5
) (
  input  logic clk_i,
  input  logic reset_i,
  mem_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [63:0]     addr_q, addr_d;
  logic [63:0]     dat_q, dat_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            wb_valid_q, wb_valid_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [63:0]     wb_dat_q, wb_dat_d;

  // The lsu returns its result zero-extended with only the low bits valid;
  // sign extension for loads happens here.
  function automatic logic [63:0] extend(input logic [63:0] d,
                                         input logic [1:0]  sz,
                                         input logic        uns);
    logic [63:0] r;
    case (sz)
      2'd1:    r = {{48{~uns & d[15]}}, d[15:0]};
      2'd2:    r = {{32{~uns & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_dat_d   = wb_dat_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          addr_d  = bus.req_addr_i;
          dat_d   = bus.req_dat_i;
          we_d    = bus.req_we_i;
          size_d  = bus.req_size_i;
          uns_d   = bus.req_unsigned_i;
          rd_d    = bus.req_rd_i;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // busy is only meaningful from the cycle after the strobe, which is
        // exactly the first WAIT cycle.
        if (!bus.lsu_busy_i) begin
          wb_dat_d   = extend(bus.lsu_dat_i, size_q, uns_q);
          wb_rd_d    = rd_q;
          // Stores and writes to x0 finish silently.
          wb_valid_d = !we_q && (rd_q != '0);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_dat_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_dat_q   <= wb_dat_d;
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.lsu_addr_o  = addr_q;
  assign bus.lsu_dat_o   = dat_q;
  // A no-memory op must never look like a store to the lsu.
  assign bus.lsu_we_o    = we_q && (size_q != 2'd0);
  assign bus.lsu_nomem_o = (state_q == ISSUE) && (size_q == 2'd0);
  assign bus.lsu_hword_o = (state_q == ISSUE) && (size_q == 2'd1);
  assign bus.lsu_word_o  = (state_q == ISSUE) && (size_q == 2'd2);
  assign bus.lsu_dword_o = (state_q == ISSUE) && (size_q == 2'd3);
  assign bus.wb_valid_o  = wb_valid_q;
  assign bus.wb_rd_o     = wb_rd_q;
  assign bus.wb_dat_o    = wb_dat_q;

endmodule
